// File: rtl/seven_segment_scanner_pkg.sv
// Shared helpers for the seven-segment scanner: segment byte assembly with polarity.
`include "seven_segment_defs.vh"

package seven_segment_scanner_pkg;

  localparam int unsigned SegWidth = 8;

  function automatic logic [SegWidth-1:0] seg_pack(logic dp_on, logic [6:0] glyph,
                                                   logic active_low);
    logic [SegWidth-1:0] v;
    v = '0;
    v[`SEG_BIT_DP]            = dp_on;
    v[`SEG_BIT_G:`SEG_BIT_A]  = glyph;
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/seg7_hex_encode.sv
// Combinational hex nibble to seven-segment glyph (gfedcba, active-high).
`include "seven_segment_defs.vh"

module seg7_hex_encode (
  input  logic [3:0] nibble_i,
  output logic [6:0] segs_o
);

  always_comb begin
    segs_o = '0;
    unique case (nibble_i)
      4'h0: segs_o = `SEG_HEX_0;
      4'h1: segs_o = `SEG_HEX_1;
      4'h2: segs_o = `SEG_HEX_2;
      4'h3: segs_o = `SEG_HEX_3;
      4'h4: segs_o = `SEG_HEX_4;
      4'h5: segs_o = `SEG_HEX_5;
      4'h6: segs_o = `SEG_HEX_6;
      4'h7: segs_o = `SEG_HEX_7;
      4'h8: segs_o = `SEG_HEX_8;
      4'h9: segs_o = `SEG_HEX_9;
      4'hA: segs_o = `SEG_HEX_A;
      4'hB: segs_o = `SEG_HEX_B;
      4'hC: segs_o = `SEG_HEX_C;
      4'hD: segs_o = `SEG_HEX_D;
      4'hE: segs_o = `SEG_HEX_E;
      4'hF: segs_o = `SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seven_segment_defs.vh
// Seven-segment glyph constants (gfedcba, active-high) and segment bit positions.
`ifndef SEVEN_SEGMENT_DEFS_VH
`define SEVEN_SEGMENT_DEFS_VH

`define SEG_BIT_A  0
`define SEG_BIT_B  1
`define SEG_BIT_C  2
`define SEG_BIT_D  3
`define SEG_BIT_E  4
`define SEG_BIT_F  5
`define SEG_BIT_G  6
`define SEG_BIT_DP 7

`define SEG_HEX_0 7'h3F
`define SEG_HEX_1 7'h06
`define SEG_HEX_2 7'h5B
`define SEG_HEX_3 7'h4F
`define SEG_HEX_4 7'h66
`define SEG_HEX_5 7'h6D
`define SEG_HEX_6 7'h7D
`define SEG_HEX_7 7'h07
`define SEG_HEX_8 7'h7F
`define SEG_HEX_9 7'h6F
`define SEG_HEX_A 7'h77
`define SEG_HEX_B 7'h7C
`define SEG_HEX_C 7'h39
`define SEG_HEX_D 7'h5E
`define SEG_HEX_E 7'h79
`define SEG_HEX_F 7'h71

`endif

// File: rtl/seven_segment_scanner.sv
// Multiplexed hex display driver: double-buffered digits, anti-ghost blanking,
// leading-zero suppression and a frame_start marker.
`include "seven_segment_defs.vh"

module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  lz_en,
  input  logic                  enable,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0]   CntLast  = CntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]   IdxLast  = IdxW'(DIGITS - 1);
  localparam logic [CntW-1:0]   CntBlank = CntW'(BLANK_CYCLES);
  localparam logic [7:0]        SegOff   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AnOff    = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : '0;

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                first_q;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                fs_q, fs_d;

  logic                boundary;
  logic [IdxW+1:0]     nib_base;
  logic [3:0]          nib;
  logic [6:0]          hex_segs;
  logic [DIGITS-1:0]   zero_above;
  logic                lz_acc;
  logic                suppress;

  // The cycle after reset is treated as a frame boundary so a load there lands at once.
  assign boundary = first_q | ((cnt_q == CntLast) & (idx_q == IdxLast));

  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    if (cnt_q == CntLast) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
    pend_val_d = load ? value : pend_val_q;
    pend_dp_d  = load ? dp : pend_dp_q;
    // Using the next pending value gives the load-at-boundary bypass for free.
    disp_val_d = boundary ? pend_val_d : disp_val_q;
    disp_dp_d  = boundary ? pend_dp_d : disp_dp_q;
  end

  assign nib_base = {idx_q, 2'b00};
  assign nib      = disp_val_q[nib_base +: 4];

  seg7_hex_encode u_hex (
    .nibble_i (nib),
    .segs_o   (hex_segs)
  );

  // zero_above[k]: nibbles k..DIGITS-1 of the display register are all zero.
  always_comb begin
    zero_above = '0;
    lz_acc     = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_acc        = lz_acc & (disp_val_q[4*k +: 4] == 4'h0);
      zero_above[k] = lz_acc;
    end
  end

  assign suppress = lz_en & (idx_q != '0) & zero_above[idx_q];

  always_comb begin
    seg_d = SegOff;
    an_d  = AnOff;
    fs_d  = (cnt_q == '0) & (idx_q == '0);
    if (enable && !(cnt_q < CntBlank)) begin
      seg_d = seg_pack(disp_dp_q[idx_q], suppress ? 7'h00 : hex_segs, SEG_ACTIVE_LOW);
      an_d  = AnOff ^ (DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      first_q    <= 1'b1;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      seg_q      <= SegOff;
      an_q       <= AnOff;
      fs_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      first_q    <= 1'b0;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      fs_q       <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner (4 digits, 8 cycles/slot, 2 blank cycles, active-low).
module tb_seven_segment_scanner;

  localparam int unsigned NDIG  = 4;
  localparam int unsigned DIV   = 8;
  localparam int unsigned BLANK = 2;
  localparam int unsigned FRAME = NDIG * DIV;

  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic       fs;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        lz_en;
  logic        enable;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

  seven_segment_scanner #(
    .DIGITS         (NDIG),
    .SCAN_DIV       (DIV),
    .BLANK_CYCLES   (BLANK),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .value       (value),
    .dp          (dp),
    .lz_en       (lz_en),
    .enable      (enable),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Reference model: m_pos is the DUT's current slot position (digit*DIV + count).
  int          m_pos = 0;
  bit          m_first = 1'b0;
  logic [15:0] m_pend_val = '0;
  logic [15:0] m_disp_val = '0;
  logic [3:0]  m_pend_dp = '0;
  logic [3:0]  m_disp_dp = '0;

  task automatic check(string tag, logic [7:0] obs, logic [7:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic model_step(output exp_t e);
    int          d;
    int          c;
    logic [15:0] upper;
    logic [6:0]  raw;
    if (rst) begin
      e.seg      = 8'hFF;
      e.an       = 4'hF;
      e.fs       = 1'b0;
      m_pos      = 0;
      m_first    = 1'b1;
      m_pend_val = '0;
      m_disp_val = '0;
      m_pend_dp  = '0;
      m_disp_dp  = '0;
    end else begin
      d    = m_pos / DIV;
      c    = m_pos % DIV;
      e.fs = (m_pos == 0);
      if (!enable || c < BLANK) begin
        e.seg = 8'hFF;
        e.an  = 4'hF;
      end else begin
        upper = m_disp_val >> (4 * d);
        raw   = (lz_en && d > 0 && upper == 16'h0) ? 7'h00 : HEX[upper[3:0]];
        e.seg = ~{m_disp_dp[d], raw};
        e.an  = ~(4'b0001 << d);
      end
      if (load) begin
        m_pend_val = value;
        m_pend_dp  = dp;
      end
      if (m_first || m_pos == FRAME - 1) begin
        m_disp_val = m_pend_val;
        m_disp_dp  = m_pend_dp;
      end
      m_pos   = (m_pos + 1) % FRAME;
      m_first = 1'b0;
    end
  endtask

  task automatic tick();
    exp_t e;
    exp_t g;
    model_step(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("seg", seg, g.seg);
    check("an", {4'h0, an}, {4'h0, g.an});
    check("frame_start", {7'h0, frame_start}, {7'h0, g.fs});
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    check("fs_reached", {7'h0, frame_start}, 8'h01);
  endtask

  task automatic goto_pos(int p);
    int n;
    n = 0;
    while (m_pos != p && n < 2 * FRAME) begin
      tick();
      n++;
    end
  endtask

  initial begin
    logic [3:0] nv;
    int         fsn;

    rst = 1'b1; load = 1'b0; value = '0; dp = '0; lz_en = 1'b0; enable = 1'b1;
    tick();
    tick();
    check("rst_seg", seg, 8'hFF);
    check("rst_an", {4'h0, an}, 8'h0F);
    check("rst_fs", {7'h0, frame_start}, 8'h00);

    // First cycle after reset is a boundary: this load is displayed in the coming frame.
    rst = 1'b0; load = 1'b1; value = 16'h12AF; dp = 4'h0;
    tick();
    load = 1'b0;
    wait_fs();
    check("f_blank0_an", {4'h0, an}, 8'h0F);
    check("f_blank0_seg", seg, 8'hFF);
    tick();
    check("f_blank1_seg", seg, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("f_an", {4'h0, an}, 8'h0E);
      check("f_seg", seg, 8'h8E);
    end

    // Sweep digit 0 through every glyph, toggling its decimal point.
    for (int n = 0; n < 16; n++) begin
      nv = 4'(n);
      value = 16'h1230 | {12'h000, nv};
      dp = {3'b000, nv[0]};
      load = 1'b1;
      tick();
      load = 1'b0;
      wait_fs();
      tick();
      tick();
      check("sweep_seg", seg, ~{nv[0], HEX[nv]});
    end

    // Leading-zero suppression.
    lz_en = 1'b1; dp = 4'h0; value = 16'h0030; load = 1'b1;
    tick();
    load = 1'b0;
    wait_fs();
    tick(); tick();
    check("lz_d0_seg", seg, 8'hC0);
    check("lz_d0_an", {4'h0, an}, 8'h0E);
    repeat (DIV) tick();
    check("lz_d1_seg", seg, 8'hB0);
    check("lz_d1_an", {4'h0, an}, 8'h0D);
    repeat (DIV) tick();
    check("lz_d2_seg", seg, 8'hFF);
    check("lz_d2_an", {4'h0, an}, 8'h0B);
    repeat (DIV) tick();
    check("lz_d3_seg", seg, 8'hFF);
    check("lz_d3_an", {4'h0, an}, 8'h07);

    // Double buffering: a mid-frame load waits for the frame boundary.
    lz_en = 1'b0; value = 16'h1111; load = 1'b1;
    tick();
    load = 1'b0;
    wait_fs();
    tick(); tick();
    check("db_old", seg, 8'hF9);
    goto_pos(2 * DIV);
    value = 16'h2222; load = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick();
    check("db_hold_seg", seg, 8'hF9);
    check("db_hold_an", {4'h0, an}, 8'h0B);
    wait_fs();
    tick(); tick();
    check("db_new", seg, 8'hA4);

    // Load on the boundary cycle itself shows up in the very next frame.
    goto_pos(FRAME - 1);
    value = 16'h3333; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("byp_fs", {7'h0, frame_start}, 8'h01);
    tick(); tick();
    check("byp_seg", seg, 8'hB0);

    // Reset in the middle of digit 2 (count 5).
    goto_pos(2 * DIV + 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_seg", seg, 8'hFF);
    check("rstmid_an", {4'h0, an}, 8'h0F);
    check("rstmid_fs", {7'h0, frame_start}, 8'h00);
    tick();
    check("rstmid_restart", {7'h0, frame_start}, 8'h01);
    tick(); tick();
    check("rstmid_disp", seg, 8'hC0);
    check("rstmid_an0", {4'h0, an}, 8'h0E);

    // Display off: outputs dark, frame_start still paced every frame.
    enable = 1'b0;
    fsn = 0;
    repeat (2 * FRAME) begin
      tick();
      if (frame_start === 1'b1) fsn++;
    end
    check("dis_fs_count", 8'(fsn), 8'd2);
    check("dis_seg", seg, 8'hFF);
    check("dis_an", {4'h0, an}, 8'h0F);
    enable = 1'b1;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 Parameters SHALL be: DIGITS, 4, number of multiplexed digits (1..8) | SCAN_DIV, 50000, clk cycles per digit slot (>= BLANK_CYCLES+1) | BLANK_CYCLES, 2, anti-ghosting dark cycles at slot start (>= 0) | SEG_ACTIVE_LOW, 1, segment polarity | AN_ACTIVE_LOW, 1, digit-enable polarity.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 load  input  1  capture value/dp into pending buffer.
REQ-005 value  input  4*DIGITS  hex nibbles; nibble k (bits 4k+3:4k) = digit k, digit 0 least significant.
REQ-006 dp  input  DIGITS  decimal point per digit.
REQ-007 lz_en  input  1  leading-zero suppression enable.
REQ-008 enable  input  1  display on; 0 forces all outputs inactive.
REQ-009 seg  output  8  segments {dp,g,f,e,d,c,b,a}, registered.
REQ-010 an  output  DIGITS  one-hot digit enable, registered.
REQ-011 frame_start  output  1  one-cycle pulse at start of each digit-0 slot.

Function
REQ-012 Slot counter cnt SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 it SHALL wrap to 0 and digit index idx SHALL advance, wrapping DIGITS-1 -> 0.
REQ-013 seg/an SHALL reflect (idx, cnt) of the previous cycle (1-cycle registered latency).
REQ-014 For cnt < BLANK_CYCLES, seg and an SHALL be all inactive; otherwise an SHALL activate only bit idx.
REQ-015 Hex encoding (gfedcba, active-high) SHALL be 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71; seg[7] = dp of displayed digit; SEG_ACTIVE_LOW inverts all 8 bits.
REQ-016 Double buffering: load SHALL write pending; pending SHALL copy into display register in the cycle cnt wraps from DIGITS-1's last cycle to digit 0 (frame boundary).
REQ-017 Multiple loads within one frame: last one SHALL win; no load: display unchanged.
REQ-018 Load coincident with frame boundary SHALL write both pending and display with the new value (bypass).
REQ-019 With lz_en=1, digit k (k>0) SHALL show all segments inactive except dp when display nibbles k..DIGITS-1 are all zero; digit 0 is never suppressed; an still pulses.
REQ-020 enable=0 SHALL force seg/an inactive next cycle; counters and buffers SHALL keep running.
REQ-021 frame_start SHALL assert for exactly the one cycle in which seg/an first reflect idx=0, cnt=0.

Reset
REQ-022 On rst: cnt=0, idx=0, pending=display=0, seg/an inactive (per polarity), frame_start=0, effective next edge; rst mid-frame SHALL abort the slot.
REQ-023 First cycle after rst deasserts SHALL count as frame boundary (frame_start pulses one cycle later).

Structure
REQ-024 Shared include seven_segment_defs.vh SHALL hold the 16 hex segment constants and bit-position defines.
REQ-025 One combinational sub-module seg7_hex_encode (4-bit nibble -> 7-bit gfedcba) SHALL be instantiated once on the selected nibble.

Verification (DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, both polarities active-low)
REQ-026 rst, load value=16'h12AF dp=0 -> after next frame_start, digit-0 slot cnt 2..7: an=4'b1110, seg=8'h8E; cnt 0..1: an=4'hF, seg=8'hFF.
REQ-027 Sweep nibble 0 through 0..F, one per frame -> seg matches ~REQ-015 table each frame; dp[0]=1 clears seg[7].
REQ-028 lz_en=1, value=16'h0030 -> digits 3,2 seg=8'hFF with an active; digit 1 seg=8'hB0; digit 0 seg=8'hC0.
REQ-029 Load 16'h1111 then 16'h2222 during digit-2 slot -> display unchanged until frame boundary, then shows 2222; load at boundary cycle -> new value in same frame.
REQ-030 rst asserted during digit-2 cnt=5 -> next cycle an=4'hF, seg=8'hFF; display=0; scanning restarts at digit 0; enable=0 -> outputs inactive, frame_start still pulses every 32 cycles.
